// File: rtl/ncpu32k_bpu_resolver.sv
// Branch prediction resolver: queues fetch-side predictions in order, checks each
// against the execute-stage outcome, and emits predictor updates and mispredict flushes.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module ncpu32k_bpu_resolver #(
  parameter int AW    = `NCPU_AW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [AW-3:0]              push_pc,
  input  logic                       push_pred_taken,
  input  logic [AW-3:0]              push_pred_tgt,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [AW-3:0]              res_tgt,
  output logic                       bpu_wb,
  output logic [AW-3:0]              bpu_wb_insn_pc,
  output logic                       bpu_wb_taken,
  output logic [AW-3:0]              bpu_wb_tgt,
  output logic                       flush,
  output logic [AW-3:0]              flush_tgt,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                stat_resolved,
  output logic [15:0]                stat_mispred
);

  localparam int WW = AW - 2;
  localparam int PW = $clog2(DEPTH);

  // Fall-through target of a branch word PC, wrapping at the top of the address space.
  function automatic logic [WW-1:0] next_word_pc(input logic [WW-1:0] pc);
    return pc + WW'(1);
  endfunction

  logic [WW-1:0] pc_mem    [DEPTH];
  logic          taken_mem [DEPTH];
  logic [WW-1:0] tgt_mem   [DEPTH];

  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full;
  logic          push_fire, res_fire, mispred;
  logic [WW-1:0] e_pc, e_tgt;
  logic          e_taken;

  logic          bpu_wb_p1, flush_p1, res_err_p1, bpu_wb_taken_p1;
  logic [WW-1:0] bpu_wb_insn_pc_p1, bpu_wb_tgt_p1, flush_tgt_p1;
  logic [15:0]   stat_resolved_p1, stat_mispred_p1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);

  // The flush cycle blocks pushes so wrong-path fetches cannot re-enter the queue.
  assign push_ready = !full && !flush_p1;
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = res_valid && !empty;

  assign e_pc    = pc_mem[rd_ptr[PW-1:0]];
  assign e_taken = taken_mem[rd_ptr[PW-1:0]];
  assign e_tgt   = tgt_mem[rd_ptr[PW-1:0]];

  // A not-taken branch never uses its target, so only a taken target is compared.
  assign mispred = (e_taken != res_taken) || (res_taken && (e_tgt != res_tgt));

  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[wr_ptr[PW-1:0]]    <= push_pc;
      taken_mem[wr_ptr[PW-1:0]] <= push_pred_taken;
      tgt_mem[wr_ptr[PW-1:0]]   <= push_pred_tgt;
    end
  end

  // ---- stage p0 -> p1: queue update and registered resolve results ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bpu_wb_p1         <= 1'b0;
      flush_p1          <= 1'b0;
      res_err_p1        <= 1'b0;
      bpu_wb_insn_pc_p1 <= '0;
      bpu_wb_taken_p1   <= 1'b0;
      bpu_wb_tgt_p1     <= '0;
      flush_tgt_p1      <= '0;
      stat_resolved_p1  <= '0;
      stat_mispred_p1   <= '0;
    end else begin
      bpu_wb_p1  <= res_fire;
      flush_p1   <= res_fire && mispred;
      res_err_p1 <= res_valid && empty;
      if (res_fire && mispred) begin
        rd_ptr <= wr_ptr;
      end else begin
        wr_ptr <= wr_ptr + (PW+1)'(push_fire);
        rd_ptr <= rd_ptr + (PW+1)'(res_fire);
      end
      if (res_fire) begin
        bpu_wb_insn_pc_p1 <= e_pc;
        bpu_wb_taken_p1   <= res_taken;
        bpu_wb_tgt_p1     <= res_tgt;
        stat_resolved_p1  <= stat_resolved_p1 + 16'd1;
        if (mispred) begin
          flush_tgt_p1    <= res_taken ? res_tgt : next_word_pc(e_pc);
          stat_mispred_p1 <= stat_mispred_p1 + 16'd1;
        end
      end
    end
  end

  assign bpu_wb         = bpu_wb_p1;
  assign bpu_wb_insn_pc = bpu_wb_insn_pc_p1;
  assign bpu_wb_taken   = bpu_wb_taken_p1;
  assign bpu_wb_tgt     = bpu_wb_tgt_p1;
  assign flush          = flush_p1;
  assign flush_tgt      = flush_tgt_p1;
  assign res_err        = res_err_p1;
  assign stat_resolved  = stat_resolved_p1;
  assign stat_mispred   = stat_mispred_p1;

endmodule

// File: doc/ncpu32k_bpu_resolver.md
Name: ncpu32k_bpu_resolver

Overview:
- Counterpart to ncpu32k_bpu on the training side: drives the bpu_wb* update interface.
- Queues every fetch-side prediction in order.
- Compares each queued prediction against the branch outcome from execute.
- Emits one predictor update per resolved branch and a redirect/flush on misprediction.

Parameters:
AW, `NCPU_AW, byte address width; PCs and targets are word addresses of AW-2 bits.
DEPTH, 4, in-flight prediction entries; power of 2, minimum 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
push_valid  in  1  fetch offers a prediction record
push_ready  out  1  record accepted when push_valid && push_ready
push_pc  in  AW-2  branch insn word PC
push_pred_taken  in  1  predicted direction
push_pred_tgt  in  AW-2  predicted target
res_valid  in  1  execute resolves oldest branch (always accepted)
res_taken  in  1  actual direction
res_tgt  in  AW-2  actual target
bpu_wb  out  1  predictor update pulse
bpu_wb_insn_pc  out  AW-2  PC of resolved branch
bpu_wb_taken  out  1  actual direction
bpu_wb_tgt  out  AW-2  actual target
flush  out  1  mispredict redirect pulse
flush_tgt  out  AW-2  correct next fetch word PC
res_err  out  1  pulse: res_valid while queue empty
count  out  clog2(DEPTH)+1  occupied entries
stat_resolved  out  16  resolved-branch counter
stat_mispred  out  16  mispredict counter

Behaviour:
- Reset (async, rst_n low): queue empty (rd/wr pointers 0), count=0.
  - bpu_wb, flush, res_err, stat_* = 0; all data outputs = 0.
  - push_ready = 1 on the first cycle after reset.
  - Reset mid-operation discards all entries immediately.
- Queue: circular buffer, pointers clog2(DEPTH)+1 bits with wrap bit.
  - full when pointer indices equal and wrap bits differ; empty when pointers equal.
- push_ready = !full && !flush; combinational, independent of same-cycle res_valid.
  - When full, a same-cycle pop does not free the slot for a push.
- Accepted push: writes {pc, pred_taken, pred_tgt} at wr_ptr and increments wr_ptr.
- Resolve at cycle T, res_valid && !empty: reads the oldest entry E.
  - mispredict = (E.pred_taken != res_taken) || (res_taken && E.pred_tgt != res_tgt).
  - Not-taken with differing pred_tgt is a correct prediction.
- Outputs at T+1, registered, 1-cycle latency, each a single-cycle pulse:
  - bpu_wb=1, bpu_wb_insn_pc=E.pc, bpu_wb_taken=res_taken, bpu_wb_tgt=res_tgt.
  - stat_resolved increments on every resolve; wraps 0xFFFF->0.
- Correct prediction: pop E (rd_ptr+1). A same-cycle push proceeds normally, so count is unchanged on simultaneous push+pop.
- Mispredict:
  - At edge T->T+1, queue is cleared (rd_ptr:=wr_ptr) and any push accepted in cycle T is discarded as wrong-path.
  - T+1: flush=1. flush_tgt = res_taken ? res_tgt : E.pc+1, modulo 2^(AW-2), so all-ones wraps to 0.
  - stat_mispred increments; wraps.
  - push_ready=0 during flush cycle T+1; pushes resume at T+2.
- res_valid while empty: no pop, no bpu_wb; res_err=1 at T+1; state otherwise unchanged.
- Data outputs hold their last value when the corresponding pulse is low.
- count reflects the registered state (post-edge).

Test Plan:
- Reset then push pc=0x100, pred_taken=1, tgt=0x200, count=1; resolve taken, tgt=0x200 -> next cycle bpu_wb=1, pc=0x100, tgt=0x200, flush=0, count=0, stat_resolved=1.
- Direction mispredict: push pc=0x40 pred_taken=1 tgt=0x80; resolve not-taken -> flush=1, flush_tgt=0x41, stat_mispred=1, push_ready=0 that cycle.
- Target mispredict with wrong-path flush: push A(pc=0x10, taken, tgt=0x20), then B, C; resolve A taken tgt=0x30 while pushing D -> flush_tgt=0x30, count=0 after flush, D dropped, push_ready=1 one cycle later.
- Full/backpressure: push 4 entries -> push_ready=0, count=4; push+resolve same cycle -> push rejected, count=3 next cycle; 5th push then accepted.
- Wrap and order: 10 push/resolve pairs with pointer wrap -> bpu_wb_insn_pc sequence matches push order; flush_tgt for pc=all-ones, actual not-taken, mispredicted -> 0.
- Error and async reset: res_valid on empty -> res_err pulse, no bpu_wb; assert rst_n low mid-stream with 3 entries -> count=0 and all outputs 0 immediately.
